// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the single-cycle 8-bit core:
//   - instruction field bit positions
//   - opcode values
//   - ALU select codes (FWD=0, ADD=1, AND=2, OR=3)
//   - decoded control bundle
//   - helper that turns an 8-bit word offset into a 32-bit byte displacement
// ----------------------------------------------------------------------------
package cpu_pkg;

  // Instruction field positions
  localparam int unsigned OP_MSB   = 31;
  localparam int unsigned OP_LSB   = 24;
  localparam int unsigned DEST_MSB = 23;
  localparam int unsigned DEST_LSB = 16;
  localparam int unsigned RD_MSB   = 18;
  localparam int unsigned RS1_MSB  = 10;
  localparam int unsigned RS1_LSB  = 8;
  localparam int unsigned RS2_MSB  = 2;
  localparam int unsigned IMM_MSB  = 7;

  typedef enum logic [7:0] {
    OP_LOADI = 8'h00,
    OP_MOV   = 8'h01,
    OP_ADD   = 8'h02,
    OP_SUB   = 8'h03,
    OP_AND   = 8'h04,
    OP_OR    = 8'h05,
    OP_J     = 8'h06,
    OP_BEQ   = 8'h07
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_FWD = 2'd0,
    ALU_ADD = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_sel_e;

  typedef struct packed {
    logic     reg_we;    // instruction writes rd
    alu_sel_e alu_sel;
    logic     use_imm;   // operand B is the immediate instead of rs2
    logic     negate_b;  // operand B is two's-complemented (sub / beq)
    logic     is_jump;
    logic     is_beq;
  } ctrl_t;

  // Sign-extend the 8-bit word offset and scale it to bytes (<< 2).
  function automatic logic [31:0] branch_offset(input logic [7:0] off);
    return {{22{off[7]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/cpu_if.sv
// ----------------------------------------------------------------------------
// cpu_if
//   Instruction-fetch bus between the core and the external instruction memory.
//   PC          : byte address of the current instruction (driven by the core)
//   INSTRUCTION : instruction word at PC, returned combinationally by memory
//   master modport = core side, slave modport = memory side.
// ----------------------------------------------------------------------------
interface cpu_if;
  logic [31:0] PC;
  logic [31:0] INSTRUCTION;

  modport master (output PC, input INSTRUCTION);
  modport slave  (input PC, output INSTRUCTION);
endinterface

// File: rtl/cpu_alu.sv
// ----------------------------------------------------------------------------
// alu
//   8-bit ALU. Subtraction is performed by the caller feeding the two's
//   complement of the second operand and selecting ADD.
//   Ports:
//     a_i, b_i   operands
//     sel_i      FWD (pass b), ADD, AND, OR
//     result_o   8-bit result, wraps mod 256
//     zero_o     result == 0
// ----------------------------------------------------------------------------
module alu
  import cpu_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  alu_sel_e   sel_i,
  output logic [7:0] result_o,
  output logic       zero_o
);

  // Operation select.
  always_comb begin
    result_o = 8'h00;
    case (sel_i)
      ALU_FWD: result_o = b_i;
      ALU_ADD: result_o = a_i + b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      default: result_o = 8'h00;
    endcase
  end

  assign zero_o = (result_o == 8'h00);

endmodule

// File: rtl/cpu_reg_file.sv
// ----------------------------------------------------------------------------
// reg_file
//   8 x 8-bit register file, two asynchronous read ports, one synchronous
//   write port, asynchronous active-high clear. Storage is kept in individually
//   named registers register0..register7 so each shows up by name in a dump.
//   Ports:
//     clk_i, rst_i                 clock / async clear
//     we_i, waddr_i, wdata_i       write port (rising edge)
//     raddr1_i -> rdata1_o         read port 1
//     raddr2_i -> rdata2_o         read port 2
// ----------------------------------------------------------------------------
module reg_file (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       we_i,
  input  logic [2:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [2:0] raddr1_i,
  output logic [7:0] rdata1_o,
  input  logic [2:0] raddr2_i,
  output logic [7:0] rdata2_o
);

  logic [7:0] register0, register1, register2, register3;
  logic [7:0] register4, register5, register6, register7;

  // Register storage: cleared while reset is high, one write per edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      register0 <= 8'h00;
      register1 <= 8'h00;
      register2 <= 8'h00;
      register3 <= 8'h00;
      register4 <= 8'h00;
      register5 <= 8'h00;
      register6 <= 8'h00;
      register7 <= 8'h00;
    end else if (we_i) begin
      case (waddr_i)
        3'd0:    register0 <= wdata_i;
        3'd1:    register1 <= wdata_i;
        3'd2:    register2 <= wdata_i;
        3'd3:    register3 <= wdata_i;
        3'd4:    register4 <= wdata_i;
        3'd5:    register5 <= wdata_i;
        3'd6:    register6 <= wdata_i;
        3'd7:    register7 <= wdata_i;
        default: register0 <= register0;
      endcase
    end
  end

  // Read port 1 mux.
  always_comb begin
    rdata1_o = 8'h00;
    case (raddr1_i)
      3'd0:    rdata1_o = register0;
      3'd1:    rdata1_o = register1;
      3'd2:    rdata1_o = register2;
      3'd3:    rdata1_o = register3;
      3'd4:    rdata1_o = register4;
      3'd5:    rdata1_o = register5;
      3'd6:    rdata1_o = register6;
      3'd7:    rdata1_o = register7;
      default: rdata1_o = 8'h00;
    endcase
  end

  // Read port 2 mux.
  always_comb begin
    rdata2_o = 8'h00;
    case (raddr2_i)
      3'd0:    rdata2_o = register0;
      3'd1:    rdata2_o = register1;
      3'd2:    rdata2_o = register2;
      3'd3:    rdata2_o = register3;
      3'd4:    rdata2_o = register4;
      3'd5:    rdata2_o = register5;
      3'd6:    rdata2_o = register6;
      3'd7:    rdata2_o = register7;
      default: rdata2_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/cpu.sv
// ----------------------------------------------------------------------------
// cpu
//   Single-cycle 8-bit core. Fetches a 32-bit instruction at PC from external
//   memory, decodes it, executes on an 8x8 register file and 8-bit ALU, and
//   commits the result and next PC on the rising clock edge.
//   Ports:
//     CLK    system clock
//     RESET  asynchronous active-high reset (PC and registers cleared at once)
//     imem   fetch bus (master): PC out, INSTRUCTION in
// ----------------------------------------------------------------------------
module cpu
  import cpu_pkg::*;
(
  input  logic  CLK,
  input  logic  RESET,
  cpu_if.master imem
);

  logic [31:0] instr_s;
  logic [7:0]  op_s;
  logic [2:0]  rd_s, rs1_s, rs2_s;
  logic [7:0]  imm_s, offset_s;
  logic        unused_src1_hi_s;

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_s, branch_target_s;

  ctrl_t       ctrl_s;
  logic [7:0]  rs1_val_s, rs2_val_s;
  logic [7:0]  b_raw_s, alu_b_s, alu_result_s;
  logic        alu_zero_s;

  assign instr_s  = imem.INSTRUCTION;
  assign op_s     = instr_s[OP_MSB:OP_LSB];
  assign rd_s     = instr_s[RD_MSB:DEST_LSB];
  assign rs1_s    = instr_s[RS1_MSB:RS1_LSB];
  assign rs2_s    = instr_s[RS2_MSB:0];
  assign imm_s    = instr_s[IMM_MSB:0];
  assign offset_s = instr_s[DEST_MSB:DEST_LSB];

  // Only the low three bits of SRC1 name a register.
  assign unused_src1_hi_s = ^instr_s[15:11];

  // Decode: undefined opcodes fall to the default and behave as no-ops.
  always_comb begin
    ctrl_s = '{reg_we: 1'b0, alu_sel: ALU_FWD, use_imm: 1'b0,
               negate_b: 1'b0, is_jump: 1'b0, is_beq: 1'b0};
    case (op_s)
      OP_LOADI: begin
        ctrl_s.reg_we  = 1'b1;
        ctrl_s.use_imm = 1'b1;
      end
      OP_MOV:  ctrl_s.reg_we = 1'b1;
      OP_ADD: begin
        ctrl_s.reg_we  = 1'b1;
        ctrl_s.alu_sel = ALU_ADD;
      end
      OP_SUB: begin
        ctrl_s.reg_we   = 1'b1;
        ctrl_s.alu_sel  = ALU_ADD;
        ctrl_s.negate_b = 1'b1;
      end
      OP_AND: begin
        ctrl_s.reg_we  = 1'b1;
        ctrl_s.alu_sel = ALU_AND;
      end
      OP_OR: begin
        ctrl_s.reg_we  = 1'b1;
        ctrl_s.alu_sel = ALU_OR;
      end
      OP_J:    ctrl_s.is_jump = 1'b1;
      OP_BEQ: begin
        // Equality test is rs1 - rs2 == 0 through the ALU zero flag.
        ctrl_s.is_beq   = 1'b1;
        ctrl_s.alu_sel  = ALU_ADD;
        ctrl_s.negate_b = 1'b1;
      end
      default: ctrl_s.reg_we = 1'b0;
    endcase
  end

  reg_file REGFILE (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .we_i     (ctrl_s.reg_we),
    .waddr_i  (rd_s),
    .wdata_i  (alu_result_s),
    .raddr1_i (rs1_s),
    .rdata1_o (rs1_val_s),
    .raddr2_i (rs2_s),
    .rdata2_o (rs2_val_s)
  );

  assign b_raw_s = ctrl_s.use_imm  ? imm_s : rs2_val_s;
  assign alu_b_s = ctrl_s.negate_b ? (~b_raw_s + 8'd1) : b_raw_s;

  alu u_alu (
    .a_i      (rs1_val_s),
    .b_i      (alu_b_s),
    .sel_i    (ctrl_s.alu_sel),
    .result_o (alu_result_s),
    .zero_o   (alu_zero_s)
  );

  assign pc_plus4_s      = pc_q + 32'd4;
  assign branch_target_s = pc_plus4_s + branch_offset(offset_s);

  // Next-PC select: jump, taken branch, or sequential.
  always_comb begin
    pc_d = pc_plus4_s;
    if (ctrl_s.is_jump || (ctrl_s.is_beq && alu_zero_s)) begin
      pc_d = branch_target_s;
    end else begin
      pc_d = pc_plus4_s;
    end
  end

  // Program counter register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_q <= 32'd0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign imem.PC = pc_q;

endmodule

// File: tb/tb_cpu.sv
module tb_cpu;

  logic CLK = 1'b0;
  logic RESET = 1'b0;

  cpu_if bus ();

  logic [31:0] mem [0:255];
  assign bus.INSTRUCTION = mem[bus.PC[9:2]];

  cpu dut (
    .CLK   (CLK),
    .RESET (RESET),
    .imem  (bus)
  );

  always #4 CLK = ~CLK;

  logic [7:0] dut_r [8];
  assign dut_r[0] = dut.REGFILE.register0;
  assign dut_r[1] = dut.REGFILE.register1;
  assign dut_r[2] = dut.REGFILE.register2;
  assign dut_r[3] = dut.REGFILE.register3;
  assign dut_r[4] = dut.REGFILE.register4;
  assign dut_r[5] = dut.REGFILE.register5;
  assign dut_r[6] = dut.REGFILE.register6;
  assign dut_r[7] = dut.REGFILE.register7;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pc"}, bus.PC, 32'd0);
    for (int i = 0; i < 8; i++) check($sformatf("%s_r%0d", tag, i), {24'd0, dut_r[i]}, 32'd0);
  endtask

  // ---------------- directed program table ----------------
  typedef struct {
    string       name;
    logic [31:0] exp_pc;
    int          reg_idx;
    logic [7:0]  exp_val;
  } step_t;

  step_t steps [13];

  task automatic load_directed();
    for (int i = 0; i < 256; i++) mem[i] = 32'hFF000000;
    mem[0]  = 32'h00040005; // loadi r4,5
    mem[1]  = 32'h00020009; // loadi r2,9
    mem[2]  = 32'h02060402; // add r6,r4,r2
    mem[3]  = 32'h07010404; // beq r4,r4,+1
    mem[4]  = 32'h06FE0000; // j -2
    mem[5]  = 32'h03010402; // sub r1,r4,r2
    mem[6]  = 32'h04050402; // and r5,r4,r2
    mem[7]  = 32'h05070402; // or  r7,r4,r2
    mem[8]  = 32'h01030004; // mov r3,r4
    mem[9]  = 32'h07010402; // beq r4,r2,+1 (not taken)
    mem[10] = 32'hFF070000; // undefined opcode, rd field = r7
    mem[11] = 32'h06F80000; // j -8 -> 0x10
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 13; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      check({tag, "_", steps[i].name, "_pc"}, bus.PC, steps[i].exp_pc);
      check({tag, "_", steps[i].name, "_reg"}, {24'd0, dut_r[steps[i].reg_idx]},
            {24'd0, steps[i].exp_val});
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int unsigned m_pc;
  int          m_regs [8];

  task automatic model_reset();
    m_pc = 0;
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
  endtask

  task automatic model_step();
    logic [31:0] w;
    int op, rd, rs1, rs2, imm, off;
    bit taken;
    w   = mem[(m_pc / 4) % 256];
    op  = int'(w[31:24]);
    rd  = int'(w[18:16]);
    rs1 = int'(w[10:8]);
    rs2 = int'(w[2:0]);
    imm = int'(w[7:0]);
    off = int'(w[23:16]);
    if (off >= 128) off = off - 256;
    taken = 1'b0;
    case (op)
      0: m_regs[rd] = imm;
      1: m_regs[rd] = m_regs[rs2];
      2: m_regs[rd] = (m_regs[rs1] + m_regs[rs2]) % 256;
      3: m_regs[rd] = (m_regs[rs1] - m_regs[rs2] + 256) % 256;
      4: m_regs[rd] = m_regs[rs1] & m_regs[rs2];
      5: m_regs[rd] = m_regs[rs1] | m_regs[rs2];
      6: taken = 1'b1;
      7: taken = (m_regs[rs1] == m_regs[rs2]);
      default: ;
    endcase
    m_pc = m_pc + 4 + (taken ? int'(off * 4) : 0);
  endtask

  task automatic random_program();
    for (int i = 0; i < 256; i++) begin
      logic [31:0] w;
      int sel;
      w   = $urandom;
      sel = int'($urandom_range(0, 9));
      if (sel <= 7) w[31:24] = 8'(sel);
      else          w[31:24] = 8'($urandom_range(8, 255));
      mem[i] = w;
    end
  endtask

  initial begin
    steps[0]  = '{"loadi_r4",    32'h04, 4, 8'h05};
    steps[1]  = '{"loadi_r2",    32'h08, 2, 8'h09};
    steps[2]  = '{"add",         32'h0C, 6, 8'h0E};
    steps[3]  = '{"beq_taken",   32'h14, 1, 8'h00};
    steps[4]  = '{"sub",         32'h18, 1, 8'hFC};
    steps[5]  = '{"and",         32'h1C, 5, 8'h01};
    steps[6]  = '{"or",          32'h20, 7, 8'h0D};
    steps[7]  = '{"mov",         32'h24, 3, 8'h05};
    steps[8]  = '{"beq_nottkn",  32'h28, 1, 8'hFC};
    steps[9]  = '{"undef_op",    32'h2C, 7, 8'h0D};
    steps[10] = '{"j_back",      32'h10, 0, 8'h00};
    steps[11] = '{"j_neg2",      32'h0C, 0, 8'h00};
    steps[12] = '{"beq_again",   32'h14, 6, 8'h0E};

    load_directed();

    // Power-on reset pulse t=2..6
    #2 RESET = 1'b1;
    #3 check_all_zero("por");
    #1 RESET = 1'b0;

    run_table("run1");

    // Asynchronous reset mid-program: must clear without any clock edge.
    #1 RESET = 1'b1;
    #1 check_all_zero("async_rst");
    @(negedge CLK);
    RESET = 1'b0;
    run_table("run2");

    // Randomized programs against the reference model.
    for (int p = 0; p < 3; p++) begin
      @(negedge CLK);
      RESET = 1'b1;
      random_program();
      model_reset();
      @(negedge CLK);
      RESET = 1'b0;
      for (int c = 0; c < 150; c++) begin
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        check($sformatf("rnd%0d_c%0d_pc", p, c), bus.PC, m_pc);
        for (int r = 0; r < 8; r++)
          check($sformatf("rnd%0d_c%0d_r%0d", p, c, r), {24'd0, dut_r[r]}, 32'(m_regs[r]));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
